uart_tx_ctrl: RTL and testbench

Transmit-side controller for the UART module. It accepts bytes over a valid/ready handshake and buffers one byte in a holding register. For each byte it builds the 11-bit frame and drives the load/shift/clear controls of the external 11-bit LSB-first shift register, paced by an internal baud-tick generator. Frames go back-to-back with no idle gap when the holding register is refilled in time.

---
 rtl/uart_pkg.sv | 34 +++
 rtl/uart_tx_ctrl_if.sv | 27 ++
 rtl/uart_baud_gen.sv | 42 ++++
 rtl/uart_tx_ctrl.sv | 142 ++++++++++++++
 tb/tb_uart_tx_ctrl.sv | 310 +++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/uart_pkg.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_pkg
// Shared constants, FSM state type and frame builder for the UART transmit
// controller.
// Contents: FRAME_W, DATA_W, STOP_IDX, PAR_IDX, tx_state_t, build_frame().
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
package uart_pkg;

  localparam int FRAME_W  = 11;
  localparam int DATA_W   = 8;
  localparam int STOP_IDX = 10;
  localparam int PAR_IDX  = 9;

  typedef enum logic {
    IDLE = 1'b0,
    SEND = 1'b1
  } tx_state_t;

  // Frame bit 0 leaves the line first: start, data LSB..MSB, parity, stop.
  // With parity disabled the parity slot becomes a second stop bit.
  function automatic logic [FRAME_W-1:0] build_frame(
    input logic [DATA_W-1:0] data,
    input logic              par_en,
    input logic              par_odd
  );
    logic par_bit;
    par_bit = par_en ? (par_odd ? ~^data : ^data) : 1'b1;
    return {1'b1, par_bit, data, 1'b0};
  endfunction

endpackage
`default_nettype wire

// File: rtl/uart_tx_ctrl_if.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_ctrl_if
// Byte-offer handshake into the UART transmit controller.
// Signals: tx_valid, tx_data[7:0], par_en, par_odd (producer -> controller),
//          tx_ready (controller -> producer).
// Modports: master (byte producer), slave (controller).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
interface uart_tx_ctrl_if;
  logic                        tx_valid;
  logic [uart_pkg::DATA_W-1:0] tx_data;
  logic                        tx_ready;
  logic                        par_en;
  logic                        par_odd;

  modport master (
    output tx_valid, tx_data, par_en, par_odd,
    input  tx_ready
  );

  modport slave (
    input  tx_valid, tx_data, par_en, par_odd,
    output tx_ready
  );
endinterface
`default_nettype wire

// File: rtl/uart_baud_gen.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_baud_gen
// Bit-period counter: counts 0..DIVISOR-1 and wraps, tick marks the last
// cycle of each bit period. clr forces the count back to 0.
// Ports: clk, arst (async, active-high), clr (sync), tick (out).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_baud_gen #(
  parameter int DIVISOR = 434
) (
  input  logic clk,
  input  logic arst,
  input  logic clr,
  output logic tick
);

  localparam int CNT_W = (DIVISOR > 1) ? $clog2(DIVISOR) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DIVISOR - 1);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;

  assign tick = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + 1'b1;
    if (clr || tick) begin
      cnt_d = '0;
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

endmodule
`default_nettype wire

// File: rtl/uart_tx_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// uart_tx_ctrl
// UART transmit controller. Accepts bytes into a one-frame holding register
// and sequences load/shift/clear of an external 11-bit LSB-first shift
// register, one bit per DIVISOR clocks, frames back-to-back when refilled.
// Ports: clk, arst (async, active-high), srst (sync clear),
//        tx (uart_tx_ctrl_if.slave handshake), sr_rst, sr_ldDat, sr_en,
//        sr_dat[10:0] (shift-register controls), busy, frame_done.
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module uart_tx_ctrl
  import uart_pkg::*;
#(
  parameter int CLK_FREQ_HZ = 50_000_000,
  parameter int BAUD        = 115200,
  parameter int DIVISOR     = CLK_FREQ_HZ / BAUD
) (
  input  logic               clk,
  input  logic               arst,
  input  logic               srst,
  uart_tx_ctrl_if.slave      tx,
  output logic               sr_rst,
  output logic               sr_ldDat,
  output logic               sr_en,
  output logic [FRAME_W-1:0] sr_dat,
  output logic               busy,
  output logic               frame_done
);

  generate
    if (DIVISOR < 2) begin : g_bad_divisor
      $error("uart_tx_ctrl: DIVISOR must be at least 2");
    end
  endgenerate

  localparam logic [3:0] LAST_BIT = 4'(STOP_IDX);

  tx_state_t          state_q, state_d;
  logic [FRAME_W-1:0] hold_q, hold_d;
  logic               hold_full_q, hold_full_d;
  logic [3:0]         bit_cnt_q, bit_cnt_d;

  logic tick;
  logic load;
  logic shift;
  logic done;
  logic accept;

  // The counter idles at 0 outside SEND so the first bit after a load is
  // exactly DIVISOR cycles long.
  uart_baud_gen #(
    .DIVISOR (DIVISOR)
  ) u_baud_gen (
    .clk  (clk),
    .arst (arst),
    .clr  (srst || load || (state_q == IDLE)),
    .tick (tick)
  );

  assign tx.tx_ready = !hold_full_q && !srst;
  assign accept      = tx.tx_valid && tx.tx_ready;

  always_comb begin
    state_d     = state_q;
    hold_d      = hold_q;
    hold_full_d = hold_full_q;
    bit_cnt_d   = bit_cnt_q;
    load        = 1'b0;
    shift       = 1'b0;
    done        = 1'b0;

    if (srst) begin
      state_d     = IDLE;
      hold_d      = '1;
      hold_full_d = 1'b0;
      bit_cnt_d   = '0;
    end else begin
      case (state_q)
        IDLE: begin
          if (hold_full_q) begin
            load      = 1'b1;
            bit_cnt_d = '0;
            state_d   = SEND;
          end
        end
        SEND: begin
          if (tick) begin
            if (bit_cnt_q < LAST_BIT) begin
              shift     = 1'b1;
              bit_cnt_d = bit_cnt_q + 4'd1;
            end else begin
              // End of stop bit: chain straight into the next frame if one
              // is waiting, so the line has no idle gap.
              done      = 1'b1;
              bit_cnt_d = '0;
              if (hold_full_q) begin
                load = 1'b1;
              end else begin
                state_d = IDLE;
              end
            end
          end
        end
        default: state_d = IDLE;
      endcase

      // A load empties the holding register; an accept in the same cycle
      // refills it, so accept takes priority.
      if (load) begin
        hold_full_d = 1'b0;
      end
      if (accept) begin
        hold_d      = build_frame(tx.tx_data, tx.par_en, tx.par_odd);
        hold_full_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge arst) begin
    if (arst) begin
      state_q     <= IDLE;
      hold_q      <= '1;
      hold_full_q <= 1'b0;
      bit_cnt_q   <= '0;
    end else begin
      state_q     <= state_d;
      hold_q      <= hold_d;
      hold_full_q <= hold_full_d;
      bit_cnt_q   <= bit_cnt_d;
    end
  end

  assign sr_rst     = srst;
  assign sr_ldDat   = load;
  assign sr_en      = shift;
  assign sr_dat     = load ? hold_q : '1;
  assign frame_done = done;
  assign busy       = (state_q == SEND) || hold_full_q;

endmodule
`default_nettype wire

// File: tb/tb_uart_tx_ctrl.sv
`default_nettype none
// ---------------------------------------------------------------------------
// tb_uart_tx_ctrl
// Self-checking bench for uart_tx_ctrl at DIVISOR=10 with an attached
// 11-bit LSB-first shift register (serial in tied high).
// Revision: 1.0 - initial release
// ---------------------------------------------------------------------------
module tb_uart_tx_ctrl;

  localparam int DIV = 10;
  localparam int FRAME_CYC = 11 * DIV;

  logic        clk;
  logic        arst;
  logic        srst;
  logic        sr_rst;
  logic        sr_ldDat;
  logic        sr_en;
  logic [10:0] sr_dat;
  logic        busy;
  logic        frame_done;

  uart_tx_ctrl_if tif ();

  uart_tx_ctrl #(
    .CLK_FREQ_HZ (1000),
    .BAUD        (100)
  ) dut (
    .clk        (clk),
    .arst       (arst),
    .srst       (srst),
    .tx         (tif.slave),
    .sr_rst     (sr_rst),
    .sr_ldDat   (sr_ldDat),
    .sr_en      (sr_en),
    .sr_dat     (sr_dat),
    .busy       (busy),
    .frame_done (frame_done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // External shift register: clear and serial-in both drive ones.
  logic [10:0] sr_q;
  logic        line;
  always @(posedge clk or posedge arst) begin
    if (arst)          sr_q <= 11'h7FF;
    else if (sr_rst)   sr_q <= 11'h7FF;
    else if (sr_ldDat) sr_q <= sr_dat;
    else if (sr_en)    sr_q <= {1'b1, sr_q[10:1]};
  end
  assign line = sr_q[0];

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int bytes_sent = 0;
  int n_load = 0;
  int n_done = 0;
  bit mon_en = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Frame as described by the line format: start, 8 data bits, parity, stop.
  function automatic logic [10:0] model_frame(input logic [7:0] d, input logic pe, input logic po);
    int ones;
    logic p;
    ones = 0;
    for (int i = 0; i < 8; i++) ones += int'(d[i]);
    if (!pe)     p = 1'b1;
    else if (po) p = ((ones % 2) == 0);
    else         p = ((ones % 2) == 1);
    return {1'b1, p, d, 1'b0};
  endfunction

  // Timeline model: a loaded frame occupies 110 cycles, bit k is on the line
  // for cycles L+1+10k .. L+10+10k, shifts happen at multiples of 10 up to
  // 100, done at 110. One pending frame may wait in the holding slot.
  bit          m_active;
  int          m_L;
  logic [10:0] m_cur;
  bit          m_hold_full;
  logic [10:0] m_hold;

  always @(negedge clk) begin
    int d;
    logic e_load, e_en, e_done, e_ready, e_busy, e_line;
    logic [10:0] e_dat;
    if (arst) begin
      m_active    = 1'b0;
      m_L         = 0;
      m_cur       = 11'h7FF;
      m_hold_full = 1'b0;
      m_hold      = 11'h7FF;
    end else if (mon_en) begin
      d       = cyc - m_L;
      e_ready = !srst && !m_hold_full;
      e_load  = !srst && m_hold_full && (!m_active || d == FRAME_CYC);
      e_en    = !srst && m_active && d > 0 && d <= 10 * DIV && (d % DIV) == 0;
      e_done  = !srst && m_active && d == FRAME_CYC;
      e_busy  = m_active || m_hold_full;
      e_dat   = e_load ? m_hold : 11'h7FF;
      e_line  = (m_active && d >= 1 && d <= FRAME_CYC) ? m_cur[(d - 1) / DIV] : 1'b1;

      chk("tx_ready",   32'(tif.tx_ready), 32'(e_ready));
      chk("sr_ldDat",   32'(sr_ldDat),     32'(e_load));
      chk("sr_en",      32'(sr_en),        32'(e_en));
      chk("frame_done", 32'(frame_done),   32'(e_done));
      chk("busy",       32'(busy),         32'(e_busy));
      chk("sr_rst",     32'(sr_rst),       32'(srst));
      chk("sr_dat",     32'(sr_dat),       32'(e_dat));
      chk("line",       32'(line),         32'(e_line));

      if (sr_ldDat)   n_load++;
      if (frame_done) n_done++;

      if (srst) begin
        m_active    = 1'b0;
        m_hold_full = 1'b0;
      end else begin
        if (e_load) begin
          m_cur       = m_hold;
          m_L         = cyc;
          m_active    = 1'b1;
          m_hold_full = 1'b0;
        end else if (e_done) begin
          m_active = 1'b0;
        end
        if (tif.tx_valid && e_ready) begin
          m_hold      = model_frame(tif.tx_data, tif.par_en, tif.par_odd);
          m_hold_full = 1'b1;
        end
      end
    end
  end

  // Offer one byte and keep it offered until accepted. When aligned is 0
  // the task first moves to just after the next rising edge.
  task automatic send(input logic [7:0] d, input logic pe, input logic po,
                      input bit keep_valid, input bit aligned);
    bit acc;
    acc = 1'b0;
    if (!aligned) begin
      @(posedge clk);
      #1;
    end
    tif.tx_data  = d;
    tif.par_en   = pe;
    tif.par_odd  = po;
    tif.tx_valid = 1'b1;
    for (int i = 0; i < 400 && !acc; i++) begin
      @(negedge clk);
      if (tif.tx_ready) acc = 1'b1;
      @(posedge clk);
      #1;
    end
    if (!keep_valid) tif.tx_valid = 1'b0;
    if (acc) bytes_sent++;
    else chk("accept_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_ld(output int c);
    bit found;
    found = 1'b0;
    c = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (sr_ldDat) begin
        found = 1'b1;
        c = cyc;
      end
    end
    if (!found) chk("load_timeout", 32'd0, 32'd1);
  endtask

  task automatic wait_done(output int c);
    bit found;
    found = 1'b0;
    c = 0;
    for (int i = 0; i < 400 && !found; i++) begin
      @(negedge clk);
      if (frame_done) begin
        found = 1'b1;
        c = cyc;
      end
    end
    if (!found) chk("done_timeout", 32'd0, 32'd1);
  endtask

  initial begin
    int l1, dn, d1, d3;
    logic [10:0] a5_bits;

    arst = 1'b1;
    srst = 1'b0;
    tif.tx_valid = 1'b0;
    tif.tx_data  = 8'h00;
    tif.par_en   = 1'b0;
    tif.par_odd  = 1'b0;

    // Pin the frame model against hand-computed frames.
    chk("model_A5_even", 32'(model_frame(8'hA5, 1'b1, 1'b0)), 32'h54A);
    chk("model_00_odd",  32'(model_frame(8'h00, 1'b1, 1'b1)), 32'h600);
    chk("model_01_off",  32'(model_frame(8'h01, 1'b0, 1'b0)), 32'h602);
    chk("model_03_even", 32'(model_frame(8'h03, 1'b1, 1'b0)), 32'h406);

    repeat (3) @(posedge clk);
    #1;
    arst = 1'b0;
    mon_en = 1'b1;

    // Reset state.
    @(negedge clk);
    chk("rst_tx_ready", 32'(tif.tx_ready), 32'd1);
    chk("rst_busy",     32'(busy),         32'd0);
    chk("rst_sr_dat",   32'(sr_dat),       32'h7FF);
    chk("rst_line",     32'(line),         32'd1);

    // Single byte 0xA5 even parity: load one cycle after accept, fixed line
    // sequence, done 110 cycles after load.
    send(8'hA5, 1'b1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    chk("a5_load_latency", 32'(sr_ldDat), 32'd1);
    chk("a5_sr_dat",       32'(sr_dat),   32'h54A);
    a5_bits = 11'b10101001010;
    for (int k = 0; k < 11; k++) begin
      @(negedge clk);
      chk("a5_line_bit", 32'(line), 32'(a5_bits[k]));
      repeat (DIV - 1) @(negedge clk);
    end
    chk("a5_frame_done", 32'(frame_done), 32'd1);
    @(negedge clk);
    chk("a5_busy_after", 32'(busy), 32'd0);

    // Parity variants.
    send(8'h00, 1'b1, 1'b1, 1'b0, 1'b0);
    wait_ld(l1);
    chk("odd_00_sr_dat", 32'(sr_dat), 32'h600);
    wait_done(dn);
    send(8'h01, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_ld(l1);
    chk("off_01_sr_dat", 32'(sr_dat), 32'h602);
    wait_done(dn);
    send(8'h03, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_ld(l1);
    chk("even_03_sr_dat", 32'(sr_dat), 32'h406);
    wait_done(dn);

    // Back-to-back: three frames, no gap, 330 cycles from first load.
    send(8'h3C, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_ld(l1);
    send(8'hC3, 1'b1, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    chk("b2b_ready_low", 32'(tif.tx_ready), 32'd0);
    wait_done(d1);
    chk("b2b_first_len",  32'(d1 - l1), 32'd110);
    chk("b2b_chain_load", 32'(sr_ldDat), 32'd1);
    send(8'h7E, 1'b0, 1'b0, 1'b0, 1'b0);
    wait_done(dn);
    wait_done(d3);
    chk("b2b_three_len", 32'(d3 - l1), 32'd330);
    @(negedge clk);

    // Byte offered through the load cycle of the previous one.
    send(8'h81, 1'b1, 1'b0, 1'b1, 1'b0);
    send(8'h18, 1'b1, 1'b1, 1'b0, 1'b1);
    wait_done(dn);
    wait_done(dn);
    @(negedge clk);
    chk("simul_all_loaded", 32'(n_load), 32'(bytes_sent));
    chk("simul_all_done",   32'(n_done), 32'(bytes_sent));

    // srst 45 cycles into a frame with a byte offered.
    send(8'hF0, 1'b1, 1'b0, 1'b0, 1'b0);
    wait_ld(l1);
    repeat (45) @(posedge clk);
    #1;
    srst = 1'b1;
    tif.tx_valid = 1'b1;
    tif.tx_data  = 8'h5A;
    @(negedge clk);
    chk("srst_sr_rst", 32'(sr_rst),       32'd1);
    chk("srst_ready",  32'(tif.tx_ready), 32'd0);
    @(posedge clk);
    #1;
    srst = 1'b0;
    tif.tx_valid = 1'b0;
    @(negedge clk);
    chk("srst_after_ready", 32'(tif.tx_ready), 32'd1);
    chk("srst_after_busy",  32'(busy),         32'd0);
    chk("srst_after_line",  32'(line),         32'd1);
    repeat (20) @(negedge clk);
    chk("srst_no_accept", 32'(n_load), 32'(bytes_sent));
    chk("srst_aborted",   32'(n_done), 32'(bytes_sent - 1));

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
